// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit scheduler.
//   tx_sched_state_e : scheduler/serializer FSM states
//   UART_IDLE_LEVEL  : level of the serial line when no frame is on it
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_sched_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at
// pointer+1 and wraps modulo N; the first asserted request wins.
// Ports:
//   req     in  N          request vector
//   pointer in  clog2(N)   index of the last winner
//   gnt     out N          one-hot grant (all zero when no request)
//   gnt_idx out clog2(N)   encoded index of the winner (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  always_comb begin : search
    int   cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Offsets 1..N visit every requester exactly once, the pointer's own
    // slot last, so the previous winner has the lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand = int'(pointer) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one 8N1 UART transmit line among NUM_REQ requesters. A round-robin
// arbiter picks a valid requester while idle; its byte is shifted out LSB
// first, each bit lasting SAMPLE strobes of sample_tick.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   sample_tick  in   one-cycle strobe at SAMPLE x baud
//   req_valid    in   NUM_REQ         per-requester byte available
//   req_data     in   NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   req_ready    out  NUM_REQ         one-hot handshake, combinational
//   tx           out  registered serial line, idle high
//   busy         out  frame in progress (START/DATA/STOP)
//   grant_id     out  owner of the current or last frame
//   frame_done   out  one-cycle pulse after the stop bit completes
// ----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int SAMPLE  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int TICK_W = $clog2(SAMPLE);
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  PTR_RESET = IDX_W'(NUM_REQ - 1);

  tx_sched_state_e    state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               tx_q, tx_d;
  logic               frame_done_q, frame_done_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               any_req;
  logic [DATA_W-1:0]  win_data;
  logic               bit_end;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign any_req  = |req_valid;
  assign win_data = req_data[arb_idx*DATA_W +: DATA_W];
  // The last tick of a bit period: the counter wraps and the bit advances.
  assign bit_end  = sample_tick && (tick_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_RESET;
      grant_id_q   <= '0;
      shift_q      <= '0;
      tick_q       <= '0;
      bit_q        <= '0;
      tx_q         <= UART_IDLE_LEVEL;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      shift_q      <= shift_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id_q;
    shift_d      = shift_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        // sample_tick is deliberately ignored here; the tick counter only
        // starts on the grant edge.
        tx_d = UART_IDLE_LEVEL;
        if (any_req) begin
          req_ready  = arb_gnt;
          state_d    = START;
          shift_d    = win_data;
          grant_id_d = arb_idx;
          ptr_d      = arb_idx;
          tick_d     = '0;
          bit_d      = '0;
          tx_d       = 1'b0;
        end
      end

      START: begin
        if (sample_tick) begin
          tick_d = tick_q + 1'b1;
        end
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (sample_tick) begin
          tick_d = tick_q + 1'b1;
        end
        if (bit_end) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            // Present the next bit in the same edge as the shift so tx
            // stays a pure register output.
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (sample_tick) begin
          tick_d = tick_q + 1'b1;
        end
        if (bit_end) begin
          tick_d       = '0;
          state_d      = IDLE;
          tx_d         = UART_IDLE_LEVEL;
          frame_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Drives the scheduler with directed and randomised requester traffic and
// compares every cycle against a frame-level reference model: a frame is a
// tick count since the grant edge, the expected line level is derived from
// ticks/SAMPLE, and grants follow the round-robin search rule.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int SAMPLE  = 16;
  localparam int FRAME   = (DATA_W + 2) * SAMPLE;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      sample_tick;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx;
  logic                      busy;
  logic [1:0]                grant_id;
  logic                      frame_done;

  logic [DATA_W-1:0] pend_data [NUM_REQ];
  logic              reassert  [NUM_REQ];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = pend_data[i];
  end

  uart_tx_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .SAMPLE  (SAMPLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx          (tx),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_active = 0;
  int          m_ticks  = 0;
  logic [7:0]  m_byte   = 8'h00;
  int          m_id     = 0;
  int          m_ptr    = NUM_REQ - 1;
  bit          m_done   = 0;
  int          cyc      = 0;
  int          grant_cyc = 0;
  int          done_cyc  = 0;
  int          grants[$];
  int          gcycs[$];

  // Stimulus knobs
  int tick_mode  = 0;   // 0: every cycle, >0: every Nth cycle, -1: random
  int tick_cnt   = 0;
  int raise_prob = 0;   // out of 16, per idle requester per cycle

  function automatic int model_winner();
    int c;
    if (m_active) return -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (m_ptr + k) % NUM_REQ;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic exp_level(int ticks, logic [7:0] b);
    int bi;
    bi = ticks / SAMPLE;
    if (bi == 0) return 1'b0;
    if (bi <= DATA_W) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic drive_next(input int consumed);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == consumed) begin
        if (reassert[i]) pend_data[i] = 8'($urandom);
        else req_valid[i] = 1'b0;
      end else if (!req_valid[i] && raise_prob > 0 && $urandom_range(0, 15) < raise_prob) begin
        req_valid[i] = 1'b1;
        pend_data[i] = 8'($urandom);
      end
    end
    if (tick_mode == 0) sample_tick = 1'b1;
    else if (tick_mode < 0) sample_tick = 1'($urandom_range(0, 1));
    else begin
      tick_cnt++;
      sample_tick = (tick_cnt % tick_mode == 0);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model on the edge,
  // then apply the next inputs shortly after the edge.
  task automatic cycle();
    int w;
    int consumed;
    logic [NUM_REQ-1:0] exp_rdy;
    @(negedge clk);
    w = model_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("tx", 32'(tx), m_active ? 32'(exp_level(m_ticks, m_byte)) : 32'd1);
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("frame_done", 32'(frame_done), 32'(m_done));
    check_val("grant_id", 32'(grant_id), 32'(m_id));
    @(posedge clk);
    cyc++;
    consumed = -1;
    if (reset) begin
      m_active = 0; m_ptr = NUM_REQ - 1; m_done = 0; m_id = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (sample_tick) begin
          m_ticks++;
          if (m_ticks == FRAME) begin
            m_active = 0; m_done = 1; done_cyc = cyc;
          end
        end
      end else if (w >= 0) begin
        m_active = 1; m_ticks = 0; m_byte = pend_data[w];
        m_id = w; m_ptr = w; grant_cyc = cyc;
        grants.push_back(w); gcycs.push_back(cyc);
        consumed = w;
      end
    end
    #1;
    drive_next(consumed);
  endtask

  task automatic run_until_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(!m_active && !m_done && req_valid == '0) && n < max_cycles);
    if (n >= max_cycles) check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    sample_tick = 1'b0;
    req_valid   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_data[i] = 8'h00;
      reassert[i]  = 1'b0;
    end

    // Reset state (checked inside cycle against model reset values)
    do_reset(3);

    // 1: single requester 2 with 8'hA5, tick every cycle
    tick_mode = 0;
    req_valid[2] = 1'b1; pend_data[2] = 8'hA5;
    grants.delete(); gcycs.delete();
    run_until_idle("p1", 400);
    check_val("p1_len", 32'(done_cyc - grant_cyc), 32'(FRAME));
    check_val("p1_grants", 32'(grants.size()), 32'd1);
    if (grants.size() > 0) check_val("p1_gid", 32'(grants[0]), 32'd2);
    for (int i = 0; i < 5; i++) cycle();

    // 2: all four valid, order 0..3 back-to-back with one extra idle cycle
    do_reset(2);
    grants.delete(); gcycs.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = 1'b1; pend_data[i] = 8'(8'h10 + i);
    end
    run_until_idle("p2", 2000);
    check_val("p2_grants", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) check_val("p2_order", 32'(grants[i]), 32'(i));
    for (int i = 1; i < gcycs.size(); i++) check_val("p2_gap", 32'(gcycs[i] - gcycs[i-1]), 32'(FRAME + 1));

    // 3: pointer now 3; requesters 1 and 3 -> 1 then 3
    grants.delete(); gcycs.delete();
    req_valid[1] = 1'b1; pend_data[1] = 8'h3C;
    req_valid[3] = 1'b1; pend_data[3] = 8'hC3;
    run_until_idle("p3", 1000);
    check_val("p3_grants", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check_val("p3_first", 32'(grants[0]), 32'd1);
      check_val("p3_second", 32'(grants[1]), 32'd3);
    end

    // 4: tick every 5th cycle; idle ticks must not start anything
    tick_mode = 5;
    for (int i = 0; i < 50; i++) cycle();
    grants.delete(); gcycs.delete();
    req_valid[0] = 1'b1; pend_data[0] = 8'h96;
    run_until_idle("p4", 1200);
    check_val("p4_len_ok", 32'((done_cyc - grant_cyc) >= 5*FRAME - 4 && (done_cyc - grant_cyc) <= 5*FRAME), 32'd1);

    // 5: reset during DATA bit 4, then lowest valid index wins
    tick_mode = 0;
    req_valid[2] = 1'b1; pend_data[2] = 8'h5A;
    n = 0;
    do begin cycle(); n++; end while (!(m_active && m_ticks == SAMPLE*5 + 3) && n < 400);
    if (n >= 400) check_val("p5_timeout", 32'd1, 32'd0);
    req_valid[1] = 1'b1; pend_data[1] = 8'hE7;
    req_valid[3] = 1'b1; pend_data[3] = 8'h18;
    grants.delete(); gcycs.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("p5_tx_after_rst", 32'(tx), 32'd1);
    check_val("p5_busy_after_rst", 32'(busy), 32'd0);
    cycle();
    check_val("p5_first_after_rst", grants.size() > 0 ? 32'(grants[0]) : 32'hFFFF, 32'd1);
    run_until_idle("p5", 2000);

    // 6: requester 0 re-asserts with new data right after each handshake
    grants.delete(); gcycs.delete();
    reassert[0] = 1'b1;
    req_valid[0] = 1'b1; pend_data[0] = 8'($urandom);
    n = 0;
    do begin cycle(); n++; end while (grants.size() < 3 && n < 1000);
    reassert[0] = 1'b0;
    run_until_idle("p6", 1000);
    for (int i = 0; i < grants.size(); i++) check_val("p6_gid", 32'(grants[i]), 32'd0);

    // 7: randomised traffic and tick rate
    tick_mode  = -1;
    raise_prob = 2;
    for (int i = 0; i < NUM_REQ; i++) reassert[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4000; i++) cycle();
    raise_prob = 0;
    for (int i = 0; i < NUM_REQ; i++) reassert[i] = 1'b0;
    run_until_idle("p7", 8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmit line among `NUM_REQ` requesters. Each requester offers a byte through a valid/ready handshake; a round-robin arbiter picks one, and an internal serializer sends it as an 8N1 frame. Bit timing comes from the oversampling strobe produced by the UART clock generator. The block sits between the firmware-facing TX sources (command responder, debug logger, status reporter) and the `tx` pad.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `DATA_W`, 8: payload bits per frame.
- `SAMPLE`, 16: `sample_tick` strobes per bit period; must match the clock generator's oversampling.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-`clk`-cycle strobe at `SAMPLE`×baud.
- `req_valid`  in  `NUM_REQ`  per-requester byte available.
- `req_data`  in  `NUM_REQ*DATA_W`  requester i's data is in bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`  one-hot, one cycle; the handshake completes when `req_valid[i]` and `req_ready[i]` are both high.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the requester owning the current or last frame.
- `frame_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, `frame_done`=0, state IDLE, tick and bit counters 0. The round-robin pointer resets to `NUM_REQ-1`, so requester 0 has first priority.
- States and transitions:
  - IDLE → START when any `req_valid` is high.
  - START → DATA after `SAMPLE` ticks.
  - DATA → STOP after `DATA_W` bits.
  - STOP → IDLE after `SAMPLE` ticks.
- Arbitration in IDLE:
  - Search from pointer+1 upward, wrapping modulo `NUM_REQ`; the first asserted `req_valid` wins.
  - `req_ready` is a combinational decode, high only in IDLE for the winner.
  - On that edge: latch the winner's byte into the shift register, load `grant_id`, set the pointer to the winner.
- Serializer:
  - START drives `tx`=0.
  - DATA drives the shift register's LSB and shifts right once per bit period, so bits go out LSB first.
  - STOP drives `tx`=1.
- Tick counter:
  - Width `$clog2(SAMPLE)`; counts only on cycles with `sample_tick`=1.
  - At `SAMPLE-1` plus a tick it wraps to 0 and advances the bit/state.
  - It clears to 0 on grant.
- Bit counter: width `$clog2(DATA_W)`; counts DATA bits 0..`DATA_W-1`.
- `frame_done` pulses on the STOP→IDLE edge. `busy` is high in START, DATA and STOP.
- `sample_tick` in IDLE is ignored.
- Requester rules:
  - Once `req_valid` is raised, it stays high and `req_data` stays stable until `req_ready`.
  - A requester may re-assert `req_valid` in the cycle after `req_ready`; it gets no priority over others because of this.
- Reset asserted mid-frame abandons the frame: `tx`=1 on the next edge, no `frame_done`, and the pointer returns to `NUM_REQ-1`.
- Non-valid requesters are never granted. Grants are fair: with all requesters valid, the order is 0,1,…,`NUM_REQ-1`,0,…

## Timing
- Grant edge N (IDLE with valid): `tx` is 0, `busy` is 1 and `grant_id` is valid after edge N.
- Start bit length is exactly `SAMPLE` ticks, counted from the first tick after edge N. The first tick period may be partial, which is acceptable.
- Frame length is `(DATA_W+2)*SAMPLE` ticks.
- `frame_done` is high for the cycle after the edge that closes STOP; the state is IDLE in that same cycle. A pending request is granted on that cycle, so frames can run back-to-back with one idle `clk` cycle of `tx`=1 added to the stop bit.
- `tx` is registered, and no combinational path from `req_*` reaches `tx`. `req_ready` is combinational from `req_valid` and state.

## Structure
- `uart_pkg` holds:
  - the `tx_sched_state_e` enum (IDLE, START, DATA, STOP);
  - the `UART_IDLE_LEVEL`=1'b1 constant.
- Sub-module `rr_arbiter` (parameter `N`):
  - inputs: `req`, `pointer`;
  - output: one-hot `gnt` plus encoded index;
  - purely combinational.
- The pointer register and the FSM live in `uart_tx_scheduler`.

## Test plan
- Reset, then only `req_valid[2]` with data 8'hA5, `sample_tick` every cycle, `SAMPLE`=16 → `req_ready[2]` for one cycle; `tx` = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; `frame_done` at cycle 160; `grant_id`=2.
- All four valid with data 8'h10..8'h13 → grant order 0,1,2,3; four frames back-to-back, each separated by one extra idle cycle; bytes appear on `tx` in that order.
- Requesters 1 and 3 valid after a grant to 3 → next grant 1, then 3; the pointer wrap is verified.
- `sample_tick` every 5th cycle → every bit lasts 80 `clk` cycles; `busy` stays high throughout; `sample_tick` in IDLE produces no state change.
- Reset asserted during DATA bit 4 → `tx`=1 and `busy`=0 after the next edge; no `frame_done`; the next grant goes to the lowest valid index.
- `req_valid[0]` held with data changing after handshake → the transmitted byte equals the data at the grant edge.
